// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for the DVP-RX async FIFO: synchronises the gray
// write pointer, tracks the read pointer, and produces empty/level/read address.

module gray2bin_converter #(
   parameter int DATA_WIDTH = 5
) (
   input  logic [DATA_WIDTH-1:0] gray,
   output logic [DATA_WIDTH-1:0] bin
);
   // Each binary bit is the XOR-reduction of the gray bits at and above it.
   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[DATA_WIDTH-1:i];
   end
endmodule

module fifo_rd_ptr_ctrl #(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH:0]   wr_ptr_gray_i,
   input  logic                  rd_ready_i,
   output logic                  rd_valid_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic [ADDR_WIDTH:0]   rd_ptr_gray_o,
   output logic                  empty_o,
   output logic [ADDR_WIDTH:0]   level_o
);
   localparam int PW = ADDR_WIDTH + 1;

   logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
   logic [PW-1:0] wr_ptr_gray_s;
   logic [PW-1:0] wr_ptr_bin_s;
   logic [PW-1:0] rd_ptr_bin;
   logic [PW-1:0] rd_ptr_bin_nxt;
   logic [PW-1:0] rd_ptr_gray_nxt;
   logic          pop;

   // Plain flop chain: nothing may sit between stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], wr_ptr_gray_i};
   end

   assign wr_ptr_gray_s = sync_q[SYNC_STAGES-1];

   gray2bin_converter #(.DATA_WIDTH(PW)) u_wr_g2b (
      .gray (wr_ptr_gray_s),
      .bin  (wr_ptr_bin_s)
   );

   // Valid comes only from the registered empty flag, never from ready.
   assign rd_valid_o      = ~empty_o;
   assign pop             = rd_valid_o & rd_ready_i;
   assign rd_ptr_bin_nxt  = rd_ptr_bin + PW'(pop);
   assign rd_ptr_gray_nxt = rd_ptr_bin_nxt ^ (rd_ptr_bin_nxt >> 1);
   assign rd_addr_o       = rd_ptr_bin[ADDR_WIDTH-1:0];

   // Flags use the post-pop pointer so popping the last word closes the window at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_bin    <= '0;
         rd_ptr_gray_o <= '0;
         empty_o       <= 1'b1;
         level_o       <= '0;
      end else begin
         rd_ptr_bin    <= rd_ptr_bin_nxt;
         rd_ptr_gray_o <= rd_ptr_gray_nxt;
         empty_o       <= (rd_ptr_gray_nxt == wr_ptr_gray_s);
         level_o       <= wr_ptr_bin_s - rd_ptr_bin_nxt;
      end
   end
endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Randomised bench for fifo_rd_ptr_ctrl against an occupancy-counting reference model.

module tb_fifo_rd_ptr_ctrl;
   localparam int AW    = 4;
   localparam int SYNC  = 2;
   localparam int DEPTH = 1 << AW;
   localparam int MOD   = 2 * DEPTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW:0]   wr_ptr_gray_i = '0;
   logic          rd_ready_i = 1'b0;
   logic          rd_valid_o;
   logic [AW-1:0] rd_addr_o;
   logic [AW:0]   rd_ptr_gray_o;
   logic          empty_o;
   logic [AW:0]   level_o;

   fifo_rd_ptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SYNC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_ptr_gray_i (wr_ptr_gray_i),
      .rd_ready_i    (rd_ready_i),
      .rd_valid_o    (rd_valid_o),
      .rd_addr_o     (rd_addr_o),
      .rd_ptr_gray_o (rd_ptr_gray_o),
      .empty_o       (empty_o),
      .level_o       (level_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: absolute word counts; the write value the reader sees is the one
   // sampled SYNC edges before the current edge.
   int w_abs, rd_abs, m_level, max_level, wraps;
   bit m_empty;
   int hist[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [AW:0] to_gray(input int v);
      logic [AW:0] b;
      b = AW'(0) + (AW+1)'(v % MOD);
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      w_abs = 0; rd_abs = 0; m_empty = 1'b1; m_level = 0;
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(0);
   endtask

   task automatic model_step(input bit rdy);
      int synced, rd;
      synced = hist[hist.size()-SYNC];
      if (!m_empty && rdy) rd_abs++;
      hist.push_back(w_abs % MOD);
      if (hist.size() > 8) void'(hist.pop_front());
      rd      = rd_abs % MOD;
      m_empty = (rd == synced);
      m_level = (synced - rd + MOD) % MOD;
   endtask

   task automatic check_all(input string ph);
      int rd;
      rd = rd_abs % MOD;
      chk({ph, ".empty"}, 32'(empty_o), 32'(m_empty));
      chk({ph, ".valid"}, 32'(rd_valid_o), 32'(!m_empty));
      chk({ph, ".level"}, 32'(level_o), 32'(m_level));
      chk({ph, ".addr"},  32'(rd_addr_o), 32'(rd % DEPTH));
      chk({ph, ".gray"},  32'(rd_ptr_gray_o), 32'(to_gray(rd)));
      if (32'(level_o) > max_level) max_level = 32'(level_o);
   endtask

   task automatic cycle(input bit rdy, input string ph);
      logic [AW:0] g_prev;
      wr_ptr_gray_i = to_gray(w_abs);
      rd_ready_i    = rdy;
      g_prev        = rd_ptr_gray_o;
      @(posedge clk);
      model_step(rdy);
      @(negedge clk);
      if (g_prev == 5'b10000 && rd_ptr_gray_o == 5'b00000) wraps++;
      check_all(ph);
   endtask

   task automatic pulse_reset(input string ph);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      wr_ptr_gray_i = '0;
      rd_ready_i    = 1'b0;
      chk({ph, ".rst_empty"}, 32'(empty_o), 32'd1);
      chk({ph, ".rst_valid"}, 32'(rd_valid_o), 32'd0);
      chk({ph, ".rst_addr"},  32'(rd_addr_o), 32'd0);
      chk({ph, ".rst_gray"},  32'(rd_ptr_gray_o), 32'd0);
      chk({ph, ".rst_level"}, 32'(level_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      max_level = 0;
      wraps     = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulse_reset("reset");

      // Sync latency: jump to bin 2, empty must fall on exactly the third edge.
      w_abs = 2;
      for (int e = 1; e <= 3; e++) begin
         cycle(1'b0, "latency");
         chk("latency.edge_empty", 32'(empty_o), 32'(e < 3));
      end
      chk("latency.level2", 32'(level_o), 32'd2);

      // Drain: two pops, third ready ignored.
      for (int e = 0; e < 3; e++) begin
         chk("drain.addr_seq", 32'(rd_addr_o), 32'(e < 2 ? e : 2));
         cycle(1'b1, "drain");
      end
      chk("drain.gray_final", 32'(rd_ptr_gray_o), 32'h03);
      chk("drain.empty_final", 32'(empty_o), 32'd1);
      chk("drain.level_final", 32'(level_o), 32'd0);

      // Full: wr bin 16 against rd 0.
      pulse_reset("full");
      w_abs = DEPTH;
      repeat (3) cycle(1'b0, "full");
      chk("full.level16", 32'(level_o), 32'(DEPTH));
      chk("full.empty0", 32'(empty_o), 32'd0);
      cycle(1'b1, "full_pop");
      repeat (2) cycle(1'b0, "full_hold");
      chk("full.level15", 32'(level_o), 32'(DEPTH-1));

      // Random write/pop traffic across several pointer laps.
      pulse_reset("rand");
      for (int c = 0; c < 800; c++) begin
         if ((w_abs - rd_abs) < DEPTH && ($urandom_range(0, 3) != 0)) w_abs++;
         cycle($urandom_range(0, 3) != 0, "rand");
      end
      chk("rand.wrap_seen", 32'(wraps > 0), 32'd1);
      chk("rand.level_max", 32'(max_level <= DEPTH), 32'd1);

      // Reset mid-stream with data pending and ready high.
      while (m_level < 7) begin
         if ((w_abs - rd_abs) < DEPTH) w_abs++;
         cycle(1'b0, "fill");
      end
      rd_ready_i = 1'b1;
      pulse_reset("midrst");
      repeat (4) cycle(1'b1, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete, errors %0d expected 0", errors);
      $fatal(1);
   end
endmodule
